// File: rtl/wmt_scan_sched_if.sv
// wmt_scan_sched_if: the scanner's bus, grouping the scan control, the meter
// inputs, the detector link and the result read-back signals.
// The slave modport is the scanner's view; the master modport is the view of
// whatever drives the scanner (CPU register block, meter pins, detector).
interface wmt_scan_sched_if #(
  parameter int NCH = 4
);
  logic           scan_en_i;
  logic [NCH-1:0] ch_mask_i;
  logic [NCH-1:0] wmt_sig_i;
  logic [15:0]    det_data_i;
  logic           det_err_i;
  logic           det_en_o;
  logic           det_sig_o;
  logic [2:0]     rd_sel_i;
  logic [15:0]    rd_data_o;
  logic [NCH-1:0] err_vec_o;
  logic [NCH-1:0] vld_vec_o;
  logic [2:0]     cur_ch_o;
  logic           busy_o;
  logic           scan_done_o;

  modport slave (
    input  scan_en_i, ch_mask_i, wmt_sig_i, det_data_i, det_err_i, rd_sel_i,
    output det_en_o, det_sig_o, rd_data_o, err_vec_o, vld_vec_o, cur_ch_o,
           busy_o, scan_done_o
  );

  modport master (
    output scan_en_i, ch_mask_i, wmt_sig_i, det_data_i, det_err_i, rd_sel_i,
    input  det_en_o, det_sig_o, rd_data_o, err_vec_o, vld_vec_o, cur_ch_o,
           busy_o, scan_done_o
  );
endinterface

// File: rtl/wmt_scan_sched.sv
// wmt_scan_sched: time-multiplexes one shared period/duty detector across NCH
// water-meter inputs. Round-robins over enabled channels: select, settle with
// the detector disabled, dwell with it enabled, then capture its result into
// a per-channel slot.
// Optional feature macro WMT_SCAN_RETRY_EN: a capture that reports an error
// gets one re-settle/re-dwell on the same channel before a result is committed.
module wmt_scan_sched #(
  parameter int NCH       = 4,
  parameter int SETTLE_US = 100,
  parameter int DWELL_US  = 600000
) (
  input logic             clk_1us,
  input logic             rstn_i,
  wmt_scan_sched_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_DWELL   = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  localparam logic [19:0] SETTLE_TC = 20'(SETTLE_US - 1);
  localparam logic [19:0] DWELL_TC  = 20'(DWELL_US - 1);

  // Next channel: lowest enabled index above cur, wrapping to the lowest
  // enabled one. A scan that starts from IDLE begins at the lowest enabled.
  function automatic logic [2:0] next_chan(input logic [NCH-1:0] mask,
                                           input logic [2:0] cur,
                                           input logic from_idle);
    logic [2:0] low;
    logic [2:0] above;
    logic       found;
    low   = 3'd0;
    above = 3'd0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      low   = mask[i] ? 3'(i) : low;
      above = (mask[i] && (3'(i) > cur)) ? 3'(i) : above;
      found = found | (mask[i] && (3'(i) > cur));
    end
    return (found && !from_idle) ? above : low;
  endfunction

  // Highest enabled channel, i.e. the last one of a pass.
  function automatic logic [2:0] high_chan(input logic [NCH-1:0] mask);
    logic [2:0] hi;
    hi = 3'd0;
    for (int i = 0; i < NCH; i++) begin
      hi = mask[i] ? 3'(i) : hi;
    end
    return hi;
  endfunction

  state_t         state_r;
  state_t         state_nxt_s;
  logic [19:0]    cnt_r;
  logic [2:0]     cur_ch_r;
  logic [2:0]     ch_nxt_s;
  logic [2:0]     last_ch_s;
  logic [NCH-1:0] mask_r;
  logic [NCH-1:0] err_r;
  logic [NCH-1:0] vld_r;
  logic [15:0]    slot_r [NCH];
  logic           first_r;
  logic           det_en_r;
  logic           busy_r;
  logic           commit_s;
  logic           det_sig_s;
  logic [15:0]    rd_data_s;
`ifdef WMT_SCAN_RETRY_EN
  logic           retry_r;
  logic           retry_s;
`endif

  assign ch_nxt_s  = next_chan(bus.ch_mask_i, cur_ch_r, first_r);
  assign last_ch_s = high_chan(mask_r);

  // Next-state decode; dropping scan_en_i aborts from any state without a capture.
  always_comb begin
    state_nxt_s = state_r;
    commit_s    = 1'b0;
`ifdef WMT_SCAN_RETRY_EN
    retry_s     = 1'b0;
`endif
    if (!bus.scan_en_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:    state_nxt_s = (bus.ch_mask_i != '0) ? ST_SELECT : ST_IDLE;
        ST_SELECT:  state_nxt_s = (bus.ch_mask_i != '0) ? ST_SETTLE : ST_IDLE;
        ST_SETTLE:  state_nxt_s = (cnt_r == SETTLE_TC) ? ST_DWELL : ST_SETTLE;
        ST_DWELL:   state_nxt_s = (cnt_r == DWELL_TC) ? ST_CAPTURE : ST_DWELL;
        ST_CAPTURE: begin
`ifdef WMT_SCAN_RETRY_EN
          if (bus.det_err_i && !retry_r) begin
            retry_s     = 1'b1;
            state_nxt_s = ST_SETTLE;
          end else begin
            commit_s    = 1'b1;
            state_nxt_s = (bus.ch_mask_i != '0) ? ST_SELECT : ST_IDLE;
          end
`else
          commit_s    = 1'b1;
          state_nxt_s = (bus.ch_mask_i != '0) ? ST_SELECT : ST_IDLE;
`endif
        end
        default:    state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register, dwell counter (cleared on each state entry) and status flags.
  always_ff @(posedge clk_1us or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 20'd0;
      det_en_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= (state_nxt_s != state_r) ? 20'd0 :
                  ((cnt_r == 20'hFFFFF) ? cnt_r : cnt_r + 20'd1);
      det_en_r <= (state_nxt_s == ST_DWELL);
      busy_r   <= (state_nxt_s != ST_IDLE);
    end
  end

  // Channel pointer and mask snapshot, both taken only when leaving SELECT.
  always_ff @(posedge clk_1us or negedge rstn_i) begin
    if (!rstn_i) begin
      cur_ch_r <= 3'd0;
      mask_r   <= '0;
      first_r  <= 1'b1;
    end else if (state_r == ST_IDLE) begin
      first_r  <= 1'b1;
    end else if ((state_r == ST_SELECT) && (state_nxt_s == ST_SETTLE)) begin
      cur_ch_r <= ch_nxt_s;
      mask_r   <= bus.ch_mask_i;
      first_r  <= 1'b0;
    end
  end

`ifdef WMT_SCAN_RETRY_EN
  // One retry per channel visit: set on an erroring capture, held through the re-dwell.
  always_ff @(posedge clk_1us or negedge rstn_i) begin
    if (!rstn_i) begin
      retry_r <= 1'b0;
    end else if (retry_s) begin
      retry_r <= 1'b1;
    end else if ((state_r != ST_SETTLE) && (state_r != ST_DWELL)) begin
      retry_r <= 1'b0;
    end
  end
`endif

  // Result slots: only the current channel is written on a committed capture.
  always_ff @(posedge clk_1us or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NCH; i++) begin
        slot_r[i] <= 16'd0;
      end
      err_r <= '0;
      vld_r <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (commit_s && (cur_ch_r == 3'(i))) begin
          slot_r[i] <= bus.det_data_i;
          err_r[i]  <= bus.det_err_i;
          vld_r[i]  <= 1'b1;
        end
      end
    end
  end

  // Meter mux and result read port; indices at or above NCH read as 0.
  always_comb begin
    det_sig_s = 1'b0;
    rd_data_s = 16'd0;
    for (int i = 0; i < NCH; i++) begin
      det_sig_s = (cur_ch_r == 3'(i)) ? bus.wmt_sig_i[i] : det_sig_s;
      rd_data_s = (bus.rd_sel_i == 3'(i)) ? slot_r[i] : rd_data_s;
    end
  end

  assign bus.det_en_o    = det_en_r;
  assign bus.det_sig_o   = det_sig_s;
  assign bus.rd_data_o   = rd_data_s;
  assign bus.err_vec_o   = err_r;
  assign bus.vld_vec_o   = vld_r;
  assign bus.cur_ch_o    = cur_ch_r;
  assign bus.busy_o      = busy_r;
  // Done marks the committing capture of the pass's last channel, so it is
  // decoded in the CAPTURE cycle itself rather than a cycle later.
  assign bus.scan_done_o = commit_s && (cur_ch_r == last_ch_s);

endmodule

// File: tb/tb_wmt_scan_sched.sv
// tb_wmt_scan_sched: directed bench with a scoreboard. Each expected dwell end
// is queued by the stimulus; a monitor pops and checks when det_en_o falls.
module tb_wmt_scan_sched;

  localparam int NCH    = 4;
  localparam int SETTLE = 10;
  localparam int DWELL  = 50;
  localparam int GAP    = SETTLE + 2;

  typedef struct {
    logic [2:0]  ch;
    logic        done;
    logic        busy;
    int          hilen;
    int          gap;
    logic [15:0] data;
    logic [3:0]  err;
    logic [3:0]  vld;
  } exp_t;

  logic        clk_1us;
  logic        rstn_i;
  logic        retry_mode;
  logic        det_en_q;
  int          ch1_dwells;
  logic [15:0] data_tab [4];
  logic [3:0]  err_tab;
  exp_t        sb [$];
  logic        mon_pend;
  int          checks;
  int          passes;

  wmt_scan_sched_if #(.NCH(NCH)) ifc ();

  wmt_scan_sched #(.NCH(NCH), .SETTLE_US(SETTLE), .DWELL_US(DWELL)) dut (
    .clk_1us (clk_1us),
    .rstn_i  (rstn_i),
    .bus     (ifc.slave)
  );

  initial clk_1us = 1'b0;
  always #5 clk_1us = ~clk_1us;

  // Detector model: fixed result per channel; in retry mode ch1 errs on its first dwell only.
  always_comb begin
    ifc.det_data_i = data_tab[ifc.cur_ch_o[1:0]];
    ifc.det_err_i  = err_tab[ifc.cur_ch_o[1:0]] |
                     (retry_mode && (ifc.cur_ch_o == 3'd1) && (ch1_dwells == 0));
  end

  // Counts completed ch1 dwells for the detector model.
  always @(posedge clk_1us) begin
    det_en_q <= ifc.det_en_o;
    if (!retry_mode) ch1_dwells <= 0;
    else if (det_en_q && !ifc.det_en_o && (ifc.cur_ch_o == 3'd1)) ch1_dwells <= ch1_dwells + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passes++;
  endtask

  task automatic push(input logic [2:0] ch, input logic done, input logic busy,
                      input int hilen, input int gap, input logic [15:0] data,
                      input logic [3:0] err, input logic [3:0] vld);
    exp_t e;
    e.ch = ch; e.done = done; e.busy = busy; e.hilen = hilen; e.gap = gap;
    e.data = data; e.err = err; e.vld = vld;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk_1us);
    rstn_i = 1'b0;
    ifc.scan_en_i = 1'b0;
    repeat (2) @(negedge clk_1us);
    rstn_i = 1'b1;
    @(negedge clk_1us);
  endtask

  task automatic wait_rises(input int n);
    int   seen;
    int   cyc;
    logic p;
    seen = 0;
    cyc  = 0;
    p    = ifc.det_en_o;
    while ((seen < n) && (cyc < 20000)) begin
      @(negedge clk_1us);
      cyc++;
      if (ifc.det_en_o && !p) seen++;
      p = ifc.det_en_o;
    end
    chk("dwell_starts", 32'(seen), 32'(n));
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (((sb.size() != 0) || mon_pend) && (cyc < 20000)) begin
      @(negedge clk_1us);
      cyc++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: measures det_en_o high/low runs and checks each dwell end against the queue.
  initial begin : monitor
    exp_t cur_e;
    logic prev;
    int   hi;
    int   lo;
    int   gap_exp;
    ifc.rd_sel_i = 3'd0;
    mon_pend = 1'b0;
    prev = 1'b0; hi = 0; lo = 0; gap_exp = 0;
    forever begin
      @(negedge clk_1us);
      if (!rstn_i) begin
        prev = 1'b0; hi = 0; lo = 0; gap_exp = 0; mon_pend = 1'b0;
      end else begin
        if (mon_pend) begin
          ifc.rd_sel_i = 3'd4; #1;
          chk("rd_sel4_zero", 32'(ifc.rd_data_o), 32'd0);
          ifc.rd_sel_i = 3'd7; #1;
          chk("rd_sel7_zero", 32'(ifc.rd_data_o), 32'd0);
          ifc.rd_sel_i = cur_e.ch; #1;
          chk("slot_data", 32'(ifc.rd_data_o), 32'(cur_e.data));
          chk("err_vec", 32'(ifc.err_vec_o), 32'(cur_e.err));
          chk("vld_vec", 32'(ifc.vld_vec_o), 32'(cur_e.vld));
          mon_pend = 1'b0;
        end
        if (ifc.det_en_o) begin
          if (!prev) begin
            if (gap_exp != 0) chk("det_en_low_gap", 32'(lo), 32'(gap_exp));
            hi = 0;
          end
          hi++;
        end else begin
          if (prev) begin
            if (sb.size() == 0) begin
              checks++;
              $display("FAIL dwell_end: unexpected on ch %0d, expected none", ifc.cur_ch_o);
            end else begin
              cur_e = sb.pop_front();
              chk("cur_ch", 32'(ifc.cur_ch_o), 32'(cur_e.ch));
              chk("scan_done", 32'(ifc.scan_done_o), 32'(cur_e.done));
              chk("busy", 32'(ifc.busy_o), 32'(cur_e.busy));
              chk("dwell_len", 32'(hi), 32'(cur_e.hilen));
              gap_exp  = cur_e.gap;
              mon_pend = 1'b1;
            end
            lo = 0;
          end
          lo++;
        end
        prev = ifc.det_en_o;
      end
    end
  end

  // Stimulus.
  initial begin : stim
    int viol;
    checks = 0; passes = 0;
    rstn_i = 1'b0; retry_mode = 1'b0;
    ifc.scan_en_i = 1'b0; ifc.ch_mask_i = 4'b0000; ifc.wmt_sig_i = 4'b0000;
    err_tab = 4'b0000;
    for (int i = 0; i < 4; i++) data_tab[i] = 16'd0;
    repeat (3) @(negedge clk_1us);
    rstn_i = 1'b1;
    @(negedge clk_1us);

    // Reset state and meter mux.
    chk("rst_busy", 32'(ifc.busy_o), 32'd0);
    chk("rst_det_en", 32'(ifc.det_en_o), 32'd0);
    chk("rst_cur_ch", 32'(ifc.cur_ch_o), 32'd0);
    chk("rst_err_vec", 32'(ifc.err_vec_o), 32'd0);
    chk("rst_vld_vec", 32'(ifc.vld_vec_o), 32'd0);
    chk("rst_done", 32'(ifc.scan_done_o), 32'd0);
    chk("rst_rd_data", 32'(ifc.rd_data_o), 32'd0);
    ifc.wmt_sig_i = 4'b0001; #1;
    chk("det_sig_hi", 32'(ifc.det_sig_o), 32'd1);
    ifc.wmt_sig_i = 4'b1110; #1;
    chk("det_sig_lo", 32'(ifc.det_sig_o), 32'd0);

    // Full mask: order 0,1,2,3,0, then abort 20 cycles into the second ch1 dwell.
    data_tab[0] = 16'd1000; data_tab[1] = 16'd1001;
    data_tab[2] = 16'd999;  data_tab[3] = 16'd1000;
    push(3'd0, 1'b0, 1'b1, DWELL, GAP, 16'd1000, 4'b0000, 4'b0001);
    push(3'd1, 1'b0, 1'b1, DWELL, GAP, 16'd1001, 4'b0000, 4'b0011);
    push(3'd2, 1'b0, 1'b1, DWELL, GAP, 16'd999,  4'b0000, 4'b0111);
    push(3'd3, 1'b1, 1'b1, DWELL, GAP, 16'd1000, 4'b0000, 4'b1111);
    push(3'd0, 1'b0, 1'b1, DWELL, GAP, 16'd1000, 4'b0000, 4'b1111);
    push(3'd1, 1'b0, 1'b0, 21,    0,   16'd1001, 4'b0000, 4'b1111);
    ifc.ch_mask_i = 4'b1111;
    ifc.scan_en_i = 1'b1;
    wait_rises(6);
    repeat (20) @(negedge clk_1us);
    ifc.scan_en_i = 1'b0;
    wait_drain();
    chk("abort_idle", 32'(ifc.busy_o), 32'd0);

    // Sparse mask with an erroring ch2.
    do_reset();
    data_tab[2] = 16'd65535; err_tab = 4'b0100;
    push(3'd0, 1'b0, 1'b1, DWELL, GAP, 16'd1000, 4'b0000, 4'b0001);
`ifdef WMT_SCAN_RETRY_EN
    push(3'd2, 1'b0, 1'b1, DWELL, SETTLE + 1, 16'd0, 4'b0000, 4'b0001);
`endif
    push(3'd2, 1'b1, 1'b1, DWELL, 0, 16'd65535, 4'b0100, 4'b0101);
    ifc.ch_mask_i = 4'b0101;
    ifc.scan_en_i = 1'b1;
    wait_drain();
    ifc.scan_en_i = 1'b0;
    err_tab = 4'b0000;

    // Empty mask keeps the scanner idle.
    do_reset();
    ifc.ch_mask_i = 4'b0000;
    ifc.scan_en_i = 1'b1;
    viol = 0;
    repeat (2000) begin
      @(negedge clk_1us);
      if (ifc.busy_o || ifc.det_en_o) viol++;
    end
    chk("mask0_idle_cycles", 32'(viol), 32'd0);

    // Asynchronous reset in the middle of a dwell clears everything, slots included.
    do_reset();
    data_tab[0] = 16'd500;
    push(3'd0, 1'b1, 1'b1, DWELL, GAP, 16'd500, 4'b0000, 4'b0001);
    ifc.ch_mask_i = 4'b0001;
    ifc.scan_en_i = 1'b1;
    wait_rises(2);
    repeat (10) @(negedge clk_1us);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_det_en", 32'(ifc.det_en_o), 32'd0);
    chk("arst_busy", 32'(ifc.busy_o), 32'd0);
    chk("arst_vld_vec", 32'(ifc.vld_vec_o), 32'd0);
    chk("arst_slot0", 32'(ifc.rd_data_o), 32'd0);
    ifc.scan_en_i = 1'b0;
    chk("sb_after_arst", 32'(sb.size()), 32'd0);
    @(negedge clk_1us);
    rstn_i = 1'b1;

    // Single channel ch1 that errs on its first dwell only.
    do_reset();
    data_tab[1] = 16'd1000;
    retry_mode = 1'b1;
    @(negedge clk_1us);
`ifdef WMT_SCAN_RETRY_EN
    push(3'd1, 1'b0, 1'b1, DWELL, SETTLE + 1, 16'd0, 4'b0000, 4'b0000);
    push(3'd1, 1'b1, 1'b1, DWELL, 0, 16'd1000, 4'b0000, 4'b0010);
`else
    push(3'd1, 1'b1, 1'b1, DWELL, GAP, 16'd1000, 4'b0010, 4'b0010);
    push(3'd1, 1'b1, 1'b1, DWELL, 0, 16'd1000, 4'b0000, 4'b0010);
`endif
    ifc.ch_mask_i = 4'b0010;
    ifc.scan_en_i = 1'b1;
    wait_drain();
    ifc.scan_en_i = 1'b0;
    repeat (5) @(negedge clk_1us);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
